// File: rtl/regfile_write_arbiter.sv
// Two-source write-back arbiter for the register-file write port, with a one-entry hold per source.
// B has priority and A gets a starvation guard. Define REGARB_STATS_EN to build the commit/stall counters.
module regfile_write_arbiter #(
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [4:0]        a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [4:0]        b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              reg_write,
  output logic [4:0]        write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic [31:0]       pending_mask,
  output logic [15:0]       stat_commits,
  output logic [15:0]       stat_stalls
);

  localparam logic [3:0] STARVE_LIM4 = 4'(STARVE_LIMIT);
  localparam logic [4:0] XZR         = 5'd31;

  logic              a_full_reg, b_full_reg;
  logic [4:0]        a_idx_reg, b_idx_reg;
  logic [DATA_W-1:0] a_data_reg, b_data_reg;
  logic [3:0]        starve_cnt_reg, starve_cnt_next;
  logic              reg_write_reg;
  logic [4:0]        write_idx_reg;
  logic [DATA_W-1:0] write_data_reg;

  logic              grant_a, grant_b, commit_any;
  logic [4:0]        commit_idx;
  logic [DATA_W-1:0] commit_data;

  // A is forced through once it has lost STARVE_LIMIT consecutive arbitrations.
  always_comb begin
    grant_a         = a_full_reg && (!b_full_reg || (starve_cnt_reg >= STARVE_LIM4));
    grant_b         = b_full_reg && !grant_a;
    commit_any      = grant_a || grant_b;
    commit_idx      = grant_a ? a_idx_reg  : b_idx_reg;
    commit_data     = grant_a ? a_data_reg : b_data_reg;
    starve_cnt_next = 4'd0;
    if (a_full_reg && !grant_a)
      starve_cnt_next = (starve_cnt_reg == 4'hF) ? 4'hF : starve_cnt_reg + 4'd1;
  end

  assign a_ready = !a_full_reg || grant_a;
  assign b_ready = !b_full_reg || grant_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_full_reg     <= 1'b0;
      a_idx_reg      <= '0;
      a_data_reg     <= '0;
      b_full_reg     <= 1'b0;
      b_idx_reg      <= '0;
      b_data_reg     <= '0;
      starve_cnt_reg <= 4'd0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      if (a_valid && a_ready) begin
        a_full_reg <= 1'b1;
        a_idx_reg  <= a_reg;
        a_data_reg <= a_data;
      end else if (grant_a) begin
        a_full_reg <= 1'b0;
      end
      if (b_valid && b_ready) begin
        b_full_reg <= 1'b1;
        b_idx_reg  <= b_reg;
        b_data_reg <= b_data;
      end else if (grant_b) begin
        b_full_reg <= 1'b0;
      end
    end
  end

  // Writes to XZR are consumed silently; the port keeps its last real write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_reg  <= 1'b0;
      write_idx_reg  <= '0;
      write_data_reg <= '0;
    end else begin
      reg_write_reg <= commit_any && (commit_idx != XZR);
      if (commit_any && (commit_idx != XZR)) begin
        write_idx_reg  <= commit_idx;
        write_data_reg <= commit_data;
      end
    end
  end

  assign reg_write  = reg_write_reg;
  assign write_reg  = write_idx_reg;
  assign write_data = write_data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 31; gi++) begin : g_pending
      assign pending_mask[gi] = (a_full_reg && (a_idx_reg == 5'(gi))) ||
                                (b_full_reg && (b_idx_reg == 5'(gi)));
    end
  endgenerate
  assign pending_mask[31] = 1'b0;

`ifdef REGARB_STATS_EN
  logic [15:0] commits_reg, stalls_reg;
  logic        stall_now;

  assign stall_now = (a_valid && !a_ready) || (b_valid && !b_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      commits_reg <= 16'd0;
      stalls_reg  <= 16'd0;
    end else begin
      if (commit_any && (commit_idx != XZR) && (commits_reg != 16'hFFFF))
        commits_reg <= commits_reg + 16'd1;
      if (stall_now && (stalls_reg != 16'hFFFF))
        stalls_reg <= stalls_reg + 16'd1;
    end
  end

  assign stat_commits = commits_reg;
  assign stat_stalls  = stalls_reg;
`else
  assign stat_commits = 16'd0;
  assign stat_stalls  = 16'd0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: single write, B streaming, starvation pattern,
// asynchronous reset, XZR and same-register conflict.
module tb_regfile_write_arbiter;

  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              a_valid = 1'b0, b_valid = 1'b0;
  logic              a_ready, b_ready;
  logic [4:0]        a_reg = '0, b_reg = '0;
  logic [DATA_W-1:0] a_data = '0, b_data = '0;
  logic              reg_write;
  logic [4:0]        write_reg;
  logic [DATA_W-1:0] write_data;
  logic [31:0]       pending_mask;
  logic [15:0]       stat_commits, stat_stalls;

  int errors = 0;
  int checks = 0;

  regfile_write_arbiter #(.DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .pending_mask(pending_mask), .stat_commits(stat_commits), .stat_stalls(stat_stalls)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_reg_write", 64'(reg_write), 64'd0);
    chk("rst_write_reg", 64'(write_reg), 64'd0);
    chk("rst_write_data", write_data, 64'd0);
    chk("rst_pending", 64'(pending_mask), 64'd0);
    chk("rst_ready", {62'd0, a_ready, b_ready}, 64'd3);
    tick();
    reset = 1'b1;
    tick();

    // Single A write to X5
    a_valid = 1'b1; a_reg = 5'd5; a_data = 64'h1234;
    tick();
    a_valid = 1'b0;
    chk("a5_pending", 64'(pending_mask), 64'h20);
    chk("a5_no_write_yet", 64'(reg_write), 64'd0);
    tick();
    chk("a5_reg_write", 64'(reg_write), 64'd1);
    chk("a5_write_reg", 64'(write_reg), 64'd5);
    chk("a5_write_data", write_data, 64'h1234);
    chk("a5_pending_clr", 64'(pending_mask), 64'd0);
    tick();
    chk("a5_reg_write_off", 64'(reg_write), 64'd0);
    chk("a5_write_reg_hold", 64'(write_reg), 64'd5);

    // B back-to-back X1..X4
    for (int i = 1; i <= 4; i++) begin
      b_valid = 1'b1; b_reg = 5'(i); b_data = 64'(100 + i);
      chk($sformatf("b_ready_%0d", i), 64'(b_ready), 64'd1);
      tick();
      if (i >= 2) begin
        chk($sformatf("b_wr_en_%0d", i - 1), 64'(reg_write), 64'd1);
        chk($sformatf("b_wr_reg_%0d", i - 1), 64'(write_reg), 64'(i - 1));
        chk($sformatf("b_wr_data_%0d", i - 1), write_data, 64'(99 + i));
      end
    end
    b_valid = 1'b0;
    tick();
    chk("b_wr_en_4", 64'(reg_write), 64'd1);
    chk("b_wr_reg_4", 64'(write_reg), 64'd4);
    tick();
    chk("b_idle", 64'(reg_write), 64'd0);

    // Both streaming: commits B,B,B,B,A repeating
    a_valid = 1'b1; a_reg = 5'd10; a_data = 64'hAA;
    b_valid = 1'b1; b_reg = 5'd20; b_data = 64'hBB;
    tick();
    for (int n = 0; n < 15; n++) begin
      tick();
      chk($sformatf("stream_en_%0d", n), 64'(reg_write), 64'd1);
      chk($sformatf("stream_reg_%0d", n), 64'(write_reg), (n % 5 == 4) ? 64'd10 : 64'd20);
      chk($sformatf("stream_a_ready_%0d", n), 64'(a_ready), ((n + 1) % 5 == 4) ? 64'd1 : 64'd0);
    end

    // Asynchronous reset with both holds full
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_reg_write", 64'(reg_write), 64'd0);
    chk("async_rst_pending", 64'(pending_mask), 64'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post_rst_no_commit_%0d", k), 64'(reg_write), 64'd0);
    end
    chk("post_rst_pending", 64'(pending_mask), 64'd0);

    // XZR write from A
    a_valid = 1'b1; a_reg = 5'd31; a_data = 64'hFFFF;
    chk("xzr_a_ready_pre", 64'(a_ready), 64'd1);
    tick();
    a_valid = 1'b0;
    chk("xzr_a_ready_held", 64'(a_ready), 64'd1);
    chk("xzr_pending", 64'(pending_mask), 64'd0);
    tick();
    chk("xzr_reg_write", 64'(reg_write), 64'd0);
    chk("xzr_write_data_hold", write_data, 64'd0);
    tick();
    chk("xzr_reg_write_after", 64'(reg_write), 64'd0);

    // Same-register conflict on X7
    a_valid = 1'b1; a_reg = 5'd7; a_data = 64'hA;
    b_valid = 1'b1; b_reg = 5'd7; b_data = 64'hB;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("x7_pending_both", 64'(pending_mask), 64'h80);
    tick();
    chk("x7_first_en", 64'(reg_write), 64'd1);
    chk("x7_first_reg", 64'(write_reg), 64'd7);
    chk("x7_first_data_b", write_data, 64'hB);
    chk("x7_pending_a", 64'(pending_mask), 64'h80);
    tick();
    chk("x7_second_en", 64'(reg_write), 64'd1);
    chk("x7_second_data_a", write_data, 64'hA);
    chk("x7_pending_clr", 64'(pending_mask), 64'd0);
    tick();
    chk("x7_idle", 64'(reg_write), 64'd0);
    chk("x7_final_data", write_data, 64'hA);

`ifdef REGARB_STATS_EN
    chk("stat_commits", 64'(stat_commits), 64'd2);
`else
    chk("stat_commits", 64'(stat_commits), 64'd0);
`endif
    chk("stat_stalls", 64'(stat_stalls), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
